// File: rtl/fir_ntap_pipe.sv
// Parametrised TAPS-tap masked moving-sum FIR with a fully registered adder tree.
// Optional FIR_FLUSH_EN adds a flush port that empties the delay line.
module fir_ntap_pipe #(
  parameter int W      = 16,
  parameter int TAPS   = 4,
  parameter int SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [W-1:0]                 a,
  input  logic [TAPS-1:0]              tap_mask,
`ifdef FIR_FLUSH_EN
  input  logic                         flush,
`endif
  output logic [W+$clog2(TAPS)-1:0]    s,
  output logic                         out_valid
);

  localparam int L     = $clog2(TAPS);
  localparam int SW    = W + L;
  localparam int NLEAF = 1 << L;
  localparam int CW    = $clog2(TAPS + 1);
  localparam logic [CW-1:0] FILL_FULL = CW'(TAPS);
  localparam logic [CW-1:0] FILL_ONE  = CW'(1);

  if ((TAPS < 2) || (TAPS > 32)) begin : g_bad_taps
    $error("fir_ntap_pipe: TAPS must lie in 2..32");
  end

  logic              flush_s;
  logic              accept_s;
  logic [CW-1:0]     fill_nxt_s;
  logic [CW-1:0]     fill_r;
  logic [L:0]        vld_r;
  logic [W-1:0]      x_r    [TAPS];
  logic [SW-1:0]     node_r [1:NLEAF-1];
  // Heap layout: 1..NLEAF-1 are registered tree nodes, NLEAF..2*NLEAF-1 are leaves.
  logic [SW-1:0]     tree_s [1:2*NLEAF-1];

`ifdef FIR_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  function automatic logic [SW-1:0] ext(input logic [W-1:0] v);
    logic [SW-1:0] r;
    if (SIGNED != 0) begin
      r = {{L{v[W-1]}}, v};
    end else begin
      r = {{L{1'b0}}, v};
    end
    return r;
  endfunction

  // Accept decision and saturating fill-count update.
  always_comb begin
    accept_s   = in_valid & ~flush_s;
    fill_nxt_s = fill_r;
    if (accept_s && (fill_r != FILL_FULL)) begin
      fill_nxt_s = fill_r + FILL_ONE;
    end else begin
      fill_nxt_s = fill_r;
    end
  end

  // Fill counter and the valid bit that travels alongside each tree level.
  always_ff @(posedge clk) begin
    if (reset || flush_s) begin
      fill_r <= '0;
      vld_r  <= '0;
    end else begin
      fill_r <= fill_nxt_s;
      vld_r  <= {vld_r[L-1:0], accept_s && (fill_nxt_s == FILL_FULL)};
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_line
    // Delay-line stage i: newest sample enters at index 0.
    always_ff @(posedge clk) begin
      if (reset || flush_s) begin
        x_r[i] <= '0;
      end else if (accept_s) begin
        if (i == 0) begin
          x_r[i] <= a;
        end else begin
          x_r[i] <= x_r[(i > 0) ? i - 1 : 0];
        end
      end else begin
        x_r[i] <= x_r[i];
      end
    end
  end

  // Leaves: masked, extended taps; padding leaves beyond TAPS are zero.
  for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
    if (i < TAPS) begin : g_tap
      assign tree_s[NLEAF + i] = tap_mask[i] ? ext(x_r[i]) : {SW{1'b0}};
    end else begin : g_pad
      assign tree_s[NLEAF + i] = {SW{1'b0}};
    end
  end

  for (genvar i = 1; i < NLEAF; i++) begin : g_node
    assign tree_s[i] = node_r[i];
    // Pairwise-add node: updates every cycle; only the valid bits are qualified.
    always_ff @(posedge clk) begin
      if (reset) begin
        node_r[i] <= '0;
      end else begin
        node_r[i] <= tree_s[2*i] + tree_s[2*i+1];
      end
    end
  end

  assign s         = node_r[1];
  assign out_valid = vld_r[L];

endmodule

// File: tb/tb_fir_ntap_pipe.sv
// Directed bench for fir_ntap_pipe: 4-tap unsigned, 4-tap signed and 5-tap unsigned
// instances share the sample stream; expected sums are hand-computed.
module tb_fir_ntap_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] a;
  logic [3:0]  mask4;
  logic [4:0]  mask5;
  logic [17:0] s4, ss;
  logic [18:0] s5;
  logic        ov4, ovs, ov5;
`ifdef FIR_FLUSH_EN
  logic        flush;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_ntap_pipe #(.W(16), .TAPS(4), .SIGNED(0)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .tap_mask(mask4),
`ifdef FIR_FLUSH_EN
    .flush(flush),
`endif
    .s(s4), .out_valid(ov4));

  fir_ntap_pipe #(.W(16), .TAPS(4), .SIGNED(1)) duts (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .tap_mask(mask4),
`ifdef FIR_FLUSH_EN
    .flush(flush),
`endif
    .s(ss), .out_valid(ovs));

  fir_ntap_pipe #(.W(16), .TAPS(5), .SIGNED(0)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .tap_mask(mask5),
`ifdef FIR_FLUSH_EN
    .flush(flush),
`endif
    .s(s5), .out_valid(ov5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic v, input logic [15:0] d);
    in_valid = v;
    a        = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = 16'd0; mask4 = 4'hF; mask5 = 5'h1F;
`ifdef FIR_FLUSH_EN
    flush = 1'b0;
`endif
    cyc(1'b0, 16'd0);
    cyc(1'b0, 16'd0);
    chk("rst_s4", 32'(s4), 32'd0);
    chk("rst_ov4", 32'(ov4), 32'd0);
    chk("rst_s5", 32'(s5), 32'd0);
    chk("rst_ov5", 32'(ov5), 32'd0);
    reset = 1'b0;

    // Warm-up: 1..5, results of 4 and 5 at +2 cycles
    cyc(1'b1, 16'd1); chk("warm_e1", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd2); chk("warm_e2", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd3); chk("warm_e3", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd4); chk("warm_e4", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd5); chk("warm_e5", 32'(ov4), 32'd0);
    cyc(1'b0, 16'd0);
    chk("warm_ov_s4", 32'(ov4), 32'd1);
    chk("warm_sum4", 32'(s4), 32'd10);
    chk("warm_sumsgn", 32'(ss), 32'd10);
    cyc(1'b0, 16'd0);
    chk("warm_sum5th", 32'(s4), 32'd14);
    chk("warm_ov5th", 32'(ov4), 32'd1);
    chk("t5_early_ov", 32'(ov5), 32'd0);
    cyc(1'b0, 16'd0);
    chk("warm_ov_gap", 32'(ov4), 32'd0);
    chk("t5_sum15", 32'(s5), 32'd15);
    chk("t5_ov", 32'(ov5), 32'd1);

    // Max value
    repeat (4) cyc(1'b1, 16'hFFFF);
    cyc(1'b0, 16'd0);
    cyc(1'b0, 16'd0);
    chk("max_u", 32'(s4), 32'h3FFFC);
    chk("max_ov", 32'(ov4), 32'd1);
    chk("max_s", 32'(ss), 32'h3FFFC);

    // Sign mode; 5-tap max-mix result lands on the first capture edge
    cyc(1'b1, 16'h8000);
    chk("t5_max", 32'(s5), 32'h40001);
    cyc(1'b1, 16'h7FFF);
    cyc(1'b1, 16'h0001);
    cyc(1'b1, 16'hFFFF);
    cyc(1'b0, 16'd0);
    cyc(1'b0, 16'd0);
    chk("sign_u", 32'(s4), 32'h1FFFF);
    chk("sign_s", 32'(ss), 32'h3FFFF);
    chk("sign_ov", 32'(ovs), 32'd1);
    cyc(1'b0, 16'd0);
    chk("t5_sign", 32'(s5), 32'h2FFFE);

    // Gaps 1,0,0,1 then mask change
    cyc(1'b1, 16'd10);
    cyc(1'b0, 16'd0);
    cyc(1'b0, 16'd0); chk("gap_ov1", 32'(ov4), 32'd1); chk("gap_s1", 32'(s4), 32'h18009);
    cyc(1'b1, 16'd20); chk("gap_ov2", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd30); chk("gap_ov3", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd40); chk("gap_ov4", 32'(ov4), 32'd1); chk("gap_s4", 32'(s4), 32'h1001E);
    mask4 = 4'b0101;
    cyc(1'b0, 16'd0); chk("mask_prev", 32'(s4), 32'h1003B);
    cyc(1'b0, 16'd0);
    chk("mask_sum", 32'(s4), 32'd60);
    chk("mask_ov", 32'(ov4), 32'd1);
    chk("mask_sgn", 32'(ss), 32'd60);
    mask4 = 4'hF;

    // Reset with results in flight
    cyc(1'b1, 16'd5);
    reset = 1'b1;
    cyc(1'b1, 16'd6);
    chk("rstm_s", 32'(s4), 32'd0);
    chk("rstm_ov", 32'(ov4), 32'd0);
    reset = 1'b0;
    cyc(1'b0, 16'd0);
    chk("rstm_ov_a", 32'(ov4), 32'd0);
    chk("rstm_s_a", 32'(s4), 32'd0);
    cyc(1'b0, 16'd0);
    chk("rstm_ov5", 32'(ov5), 32'd0);

    // Odd taps from empty line
    cyc(1'b1, 16'd1);
    cyc(1'b1, 16'd2);
    cyc(1'b1, 16'd3);
    cyc(1'b1, 16'd4);
    cyc(1'b1, 16'd5);
    cyc(1'b0, 16'd0);
    cyc(1'b0, 16'd0);
    chk("odd_ov5_early", 32'(ov5), 32'd0);
    chk("odd_s4", 32'(s4), 32'd14);
    cyc(1'b0, 16'd0);
    chk("odd_s5", 32'(s5), 32'd15);
    chk("odd_ov5", 32'(ov5), 32'd1);

`ifdef FIR_FLUSH_EN
    flush = 1'b1;
    cyc(1'b1, 16'd100);
    flush = 1'b0;
    chk("fl_keep_s", 32'(s4), 32'd14);
    chk("fl_ov", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd7);  chk("fl_ov1", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd8);  chk("fl_ov2", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd9);  chk("fl_ov3", 32'(ov4), 32'd0);
    cyc(1'b1, 16'd11); chk("fl_ov4", 32'(ov4), 32'd0);
    cyc(1'b0, 16'd0);  chk("fl_ov5", 32'(ov4), 32'd0);
    cyc(1'b0, 16'd0);
    chk("fl_sum", 32'(s4), 32'd35);
    chk("fl_ovr", 32'(ov4), 32'd1);
    chk("fl_t5_ov", 32'(ov5), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_ntap_pipe.md
Name: fir_ntap_pipe

Overview:
- Parametrised N-tap moving-sum FIR with a valid-qualified input and a fully pipelined, registered adder tree; next generation of the fixed 4-tap sum filter.
- Computes the sum of the TAPS most recent accepted samples, with each tap individually maskable.
- Unsigned or two's-complement operation; output is full precision, so it never overflows.
- Sits between the sample source and the downstream decimator/accumulator in the datapath.

Parameters:
- W, 16, sample width in bits.
- TAPS, 4, number of taps; legal range 2..32, power of two not required.
- SIGNED, 0, 0 = unsigned samples, 1 = two's-complement samples (sign-extended into the tree).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  sample on a is accepted at this edge when high.
- a  input  W  sample data.
- tap_mask  input  TAPS  bit i high = tap i contributes; bit 0 = newest sample; sampled every cycle.
- s  output  W+L  filter sum, where L = $clog2(TAPS).
- out_valid  output  1  s holds a new result this cycle.
- flush  input  1  (only when FIR_FLUSH_EN is defined) clears the delay line.

Behaviour:
- Reset (synchronous, active-high):
  - Clears every delay-line register, tree register, valid pipe bit and the fill counter.
  - s = 0, out_valid = 0 in the cycle after the reset edge.
  - Reset mid-stream discards all in-flight results; no out_valid may rise from pre-reset samples.
- Delay line: TAPS registers x[0..TAPS-1].
  - On an edge with in_valid = 1: x[0] <= a and x[i] <= x[i-1].
  - With in_valid = 0 the line holds its contents.
- Fill counter:
  - Increments on each accepted sample and saturates at TAPS.
  - A sample is "valid-to-output" only if the counter equals TAPS after its capture, i.e. the delay line is full.
- Tree input: operand i = tap_mask[i] ? ext(x[i]) : 0.
  - ext is zero-extension when SIGNED = 0 and sign-extension when SIGNED = 1, to W+L bits.
  - Operands are padded with zeros up to 2^L leaves.
- Adder tree and latency:
  - L registered pairwise-add levels; the last level register is s.
  - A result whose sample was captured at edge k appears on s after edge k+L, with out_valid = 1 for exactly that one cycle.
  - TAPS = 2 gives L = 1.
- Pipeline: no stall. A valid bit travels alongside each tree level; tree registers update every cycle regardless of valid.
- out_valid:
  - Equals the valid bit exiting level L.
  - Back-to-back accepted samples give back-to-back out_valid pulses.
  - in_valid gaps give matching gaps in out_valid.
- s between pulses: holds whatever the tree last produced. Consumers qualify s with out_valid only.
- tap_mask:
  - The value present in the cycle after the capture edge applies to that sample's sum.
  - A mask change mid-stream affects only later results.
- Arithmetic: modulo 2^(W+L). With full-width growth no overflow is possible for any input.

Optional Feature:
- Macro: FIR_FLUSH_EN.
- Defined:
  - The flush port exists.
  - flush = 1 at an edge clears x[], the fill counter and all valid pipe bits; it does not clear s.
  - If in_valid = 1 on the same edge, flush wins and the sample is dropped.
  - The next TAPS accepted samples refill the line before out_valid returns.
- Not defined: no flush port; only reset clears state.

Test Plan:
- Warm-up, W=16, TAPS=4, SIGNED=0, mask = 4'hF: accept 1,2,3,4 on consecutive cycles -> out_valid stays low through the first three samples, then pulses 2 cycles after sample 4 is captured with s = 18'd10. Sample 5 -> s = 18'd14 on the next cycle.
- Max-value check: four samples of 16'hFFFF -> s = 18'h3FFFC, with no wrap.
- Sign mode: accept 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF.
  - SIGNED=1 -> s = 18'h3FFFF (-1).
  - SIGNED=0 -> s = 18'h1FFFF.
- Gaps and mask: with the line full, drive in_valid 1,0,0,1 -> out_valid pattern 1,0,0,1 delayed by 2 cycles. Mask 4'b0101 on samples 10,20,30,40 (40 newest) -> s = 40+20 = 60.
- Reset and odd taps: assert reset 1 cycle after a capture while results are in flight -> out_valid never rises for those samples, and s = 0. Then TAPS=5 (L=3) with samples 1..5 -> s = 15 three cycles after the fifth capture.
- FIR_FLUSH_EN: flush asserted together with in_valid on the line-full stream -> sample dropped; out_valid low until 4 new samples are accepted; next s equals the sum of only those 4.
